// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions: framing constants, CRC-32
// parameters, the receive FSM state type and small byte helpers.
package eth_pkg;

  typedef enum logic [1:0] {
    DROP,
    IDLE,
    PREAMBLE,
    DATA
  } rx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam int              LEN_W   = 11;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  // The wire carries bits LSB first, so the shift register uses the mirrored polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = addr[47:40];
      3'd1:    b = addr[39:32];
      3'd2:    b = addr[31:24];
      3'd3:    b = addr[23:16];
      3'd4:    b = addr[15:8];
      3'd5:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mac_rx_frame_if.sv
// Receive-path bundle: PHY byte stream in, delineated frame bytes and
// per-frame status out. The slave side is the frame delineator.
interface mac_rx_frame_if;

  logic [7:0]  in_data;
  logic        in_dv;
  logic        in_er;
  logic        promisc;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;

  logic        stat_valid;
  logic        stat_good;
  logic        stat_crc_err;
  logic        stat_len_err;
  logic        stat_phy_err;
  logic        stat_addr_miss;
  logic [10:0] stat_len;

  modport master (
    output in_data, in_dv, in_er, promisc,
    input  out_data, out_valid, out_sof, out_eof,
    input  stat_valid, stat_good, stat_crc_err, stat_len_err,
    input  stat_phy_err, stat_addr_miss, stat_len
  );

  modport slave (
    input  in_data, in_dv, in_er, promisc,
    output out_data, out_valid, out_sof, out_eof,
    output stat_valid, stat_good, stat_crc_err, stat_len_err,
    output stat_phy_err, stat_addr_miss, stat_len
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 step: folds one byte (LSB first) into the
// running register. Shared with the transmit FCS generator.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/mac_rx_frame.sv
// Receive frame delineator: strips preamble/SFD, forwards DA..payload with the
// FCS held back by a 5-byte delay line, and reports CRC/length/address/PHY status.
module mac_rx_frame
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518
) (
  input logic           phy_rx_clk,
  input logic           rst,
  mac_rx_frame_if.slave rx
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);

  rx_state_t  state;
  rx_state_t  next_state;
  logic [4:0] pre_cnt;
  logic [4:0] pre_cnt_next;
  logic       start_frame;
  logic       take_byte;
  logic       end_frame;

  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] len;
  logic [7:0]       sr [5];
  logic             phy_err;
  logic             da_eq;
  logic             da_bcast;
  logic             da_mcast;
  logic             addr_hit;
  logic             crc_bad;
  logic             len_bad;

  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             out_sof_q;
  logic             out_eof_q;
  logic             stat_valid_q;
  logic             stat_good_q;
  logic             stat_crc_err_q;
  logic             stat_len_err_q;
  logic             stat_phy_err_q;
  logic             stat_addr_miss_q;
  logic [LEN_W-1:0] stat_len_q;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (rx.in_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge phy_rx_clk) begin
    if (rst) begin
      state   <= DROP;
      pre_cnt <= '0;
    end else begin
      state   <= next_state;
      pre_cnt <= pre_cnt_next;
    end
  end

  // Carrier that starts with anything but a clean preamble is ignored until dv drops.
  always_comb begin
    next_state   = state;
    pre_cnt_next = pre_cnt;
    start_frame  = 1'b0;
    take_byte    = 1'b0;
    end_frame    = 1'b0;
    case (state)
      DROP: begin
        if (!rx.in_dv) next_state = IDLE;
      end
      IDLE: begin
        if (rx.in_dv) begin
          if (rx.in_data == ETH_PREAMBLE) begin
            next_state   = PREAMBLE;
            pre_cnt_next = 5'd1;
          end else begin
            next_state = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx.in_dv) begin
          next_state = IDLE;
        end else if (rx.in_data == ETH_PREAMBLE) begin
          if (pre_cnt == 5'd15) next_state = DROP;
          else                  pre_cnt_next = pre_cnt + 5'd1;
        end else if (rx.in_data == ETH_SFD) begin
          next_state  = DATA;
          start_frame = 1'b1;
        end else begin
          next_state = DROP;
        end
      end
      DATA: begin
        if (rx.in_dv) begin
          take_byte = 1'b1;
        end else begin
          end_frame  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = DROP;
    endcase
  end

  // A frame too short to hold a full DA only passes the filter via multicast or promisc.
  always_comb begin
    addr_hit = rx.promisc || da_mcast || ((len >= 11'd6) && (da_eq || da_bcast));
    crc_bad  = (len <= 11'd4) || (crc != CRC32_RESIDUE);
    len_bad  = (len < MIN_LEN) || (len > MAX_LEN);
  end

  always_ff @(posedge phy_rx_clk) begin
    if (rst) begin
      crc              <= '0;
      len              <= '0;
      phy_err          <= 1'b0;
      da_eq            <= 1'b0;
      da_bcast         <= 1'b0;
      da_mcast         <= 1'b0;
      for (int i = 0; i < 5; i++) sr[i] <= '0;
      out_data_q       <= '0;
      out_valid_q      <= 1'b0;
      out_sof_q        <= 1'b0;
      out_eof_q        <= 1'b0;
      stat_valid_q     <= 1'b0;
      stat_good_q      <= 1'b0;
      stat_crc_err_q   <= 1'b0;
      stat_len_err_q   <= 1'b0;
      stat_phy_err_q   <= 1'b0;
      stat_addr_miss_q <= 1'b0;
      stat_len_q       <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      stat_valid_q <= 1'b0;

      if (start_frame) begin
        crc      <= CRC32_INIT;
        len      <= '0;
        phy_err  <= 1'b0;
        da_eq    <= 1'b1;
        da_bcast <= 1'b1;
        da_mcast <= 1'b0;
      end

      if (take_byte) begin
        sr[0] <= rx.in_data;
        for (int i = 1; i < 5; i++) sr[i] <= sr[i-1];
        crc <= crc_next;
        if (len != LEN_SAT) len <= len + 11'd1;
        if (rx.in_er) phy_err <= 1'b1;
        if (len < 11'd6) begin
          if (rx.in_data != addr_byte(MAC_ADDR, len[2:0]))  da_eq    <= 1'b0;
          if (rx.in_data != addr_byte(ETH_BCAST, len[2:0])) da_bcast <= 1'b0;
          if (len == 11'd0) da_mcast <= rx.in_data[0];
        end
        // Once five bytes are buffered, the oldest one can no longer be FCS.
        if (len >= 11'd5) begin
          out_data_q  <= sr[4];
          out_valid_q <= 1'b1;
          out_sof_q   <= (len == 11'd5);
        end
      end

      if (end_frame) begin
        if (len >= 11'd5) begin
          out_data_q  <= sr[4];
          out_valid_q <= 1'b1;
          out_eof_q   <= 1'b1;
          out_sof_q   <= (len == 11'd5);
        end
        stat_valid_q     <= 1'b1;
        stat_len_q       <= len;
        stat_crc_err_q   <= crc_bad;
        stat_len_err_q   <= len_bad;
        stat_phy_err_q   <= phy_err;
        stat_addr_miss_q <= !addr_hit;
        stat_good_q      <= !(crc_bad || len_bad || phy_err || !addr_hit);
      end
    end
  end

  assign rx.out_data       = out_data_q;
  assign rx.out_valid      = out_valid_q;
  assign rx.out_sof        = out_sof_q;
  assign rx.out_eof        = out_eof_q;
  assign rx.stat_valid     = stat_valid_q;
  assign rx.stat_good      = stat_good_q;
  assign rx.stat_crc_err   = stat_crc_err_q;
  assign rx.stat_len_err   = stat_len_err_q;
  assign rx.stat_phy_err   = stat_phy_err_q;
  assign rx.stat_addr_miss = stat_addr_miss_q;
  assign rx.stat_len       = stat_len_q;

endmodule

// File: doc/mac_rx_frame.md
# mac_rx_frame

Receive-side frame delineator that consumes the byte stream recovered from the RGMII PHY (one byte per `phy_rx_clk` with valid/error qualifiers). It strips preamble/SFD, checks FCS (CRC-32), length and destination address, and forwards DA..payload bytes with the FCS removed. It also emits a per-frame status word. It sits between the PHY receive stage and the MAC receive buffer/CDC FIFO.

## Interface
- `MAC_ADDR`, 48'h02_00_00_00_00_01: station address; byte 0 (first on wire) = bits [47:40]
- `MIN_FRAME`, 64: minimum legal length in bytes, DA through FCS
- `MAX_FRAME`, 1518: maximum legal length in bytes, DA through FCS
- `phy_rx_clk`  in  1  byte clock
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  8  received byte
- `in_dv`  in  1  byte valid / carrier
- `in_er`  in  1  PHY receive error for this byte
- `promisc`  in  1  disable address filter
- `out_data`  out  8  frame byte (DA..payload, no FCS)
- `out_valid`  out  1  `out_data` valid
- `out_sof`  out  1  first byte of frame (DA[0])
- `out_eof`  out  1  last payload byte
- `stat_valid`  out  1  one-cycle pulse at end of every frame that reached DATA
- `stat_good`  out  1  no error flags set
- `stat_crc_err`, `stat_len_err`, `stat_phy_err`, `stat_addr_miss`  out  1 each  error flags
- `stat_len`  out  11  bytes DA..FCS, saturating at 2047

## Operation
- FSM states: DROP, IDLE, PREAMBLE, DATA. Reset state is DROP.
- DROP: stays in DROP while `in_dv`=1. Goes to IDLE when `in_dv`=0.
- IDLE: on `in_dv`=1 with byte 0x55, goes to PREAMBLE with preamble count = 1. On `in_dv`=1 with any other byte, goes to DROP.
- PREAMBLE:
  - 0x55: count++. Count >15 goes to DROP.
  - 0xD5: goes to DATA. Clears CRC to 0xFFFFFFFF and clears len and flags.
  - Other byte: goes to DROP.
  - `in_dv`=0: goes to IDLE with no status.
- DATA, on each `in_dv`=1 byte:
  - Shift the byte into a 5-deep delay line `sr[0..4]`.
  - Update CRC (reflected, poly 0x04C11DB7, LSB first).
  - len++ (saturating at 2047).
  - `in_er`=1 sets phy_err.
  - Bytes 0..5 are compared against `MAC_ADDR`. Match if equal, or all 0xFF, or byte0 bit0=1 (multicast), or `promisc`=1.
- Emission: when byte j≥5 is sampled, `sr[4]` (byte j−5) is output on the next cycle. `out_sof`=1 when j=5.
- End of frame: first `in_dv`=0 in DATA. FSM goes to IDLE.
  - If len≥5: `sr[4]` (last payload byte) is output with `out_eof`=1.
  - `stat_valid`=1 in the same cycle.
  - `crc_err` = (CRC register ≠ 0xDEBB20E3 residue).
  - `len_err` = len<`MIN_FRAME` or len>`MAX_FRAME`.
  - `stat_good` = no error flags set.
- len≤4: no out bytes are produced. `stat_valid` still fires with `len_err`=1 and `crc_err`=1.
- Oversize frames keep streaming. Only the flag is set.
- `stat_*` fields hold their values until the next `stat_valid`. Downstream discards a frame on `stat_good`=0.

## Timing
- All outputs are registered. Reset values are all 0.
- Data latency: 5 input bytes + 1 cycle.
- `out_eof` and `stat_valid` occur 1 cycle after the first `in_dv`=0 sample.
- No backpressure. `out_valid` is never asserted on consecutive frames without at least 1 idle cycle.
- Reset mid-frame:
  - Next cycle all outputs are 0 and the FSM is in DROP. No eof or status is emitted for the aborted frame.
  - A frame whose `in_dv` is still high stays ignored until `in_dv` deasserts.
- `in_dv` dropping in PREAMBLE is not a frame and emits no status.
- Back-to-back frames with 1 idle cycle (dv low) are fully supported. The IDLE→PREAMBLE transition happens on the first 0x55 of the next frame.

## Structure
- Package `eth_pkg` holds:
  - FSM state enum
  - `ETH_PREAMBLE`=8'h55, `ETH_SFD`=8'hD5
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_RESIDUE`=32'hDEBB20E3
  - `ETH_BCAST`
- Sub-module `crc32_d8`: combinational next-CRC for one byte (crc_in, data → crc_out). It is reused by the TX FCS generator.

## Test plan
- 7×0x55, 0xD5, 60-byte frame to `MAC_ADDR` + correct FCS (64 bytes) → 60 out bytes, sof on DA[0], eof on byte 59, `stat_good`=1, `stat_len`=64.
- Same frame with one payload bit flipped → identical data stream, `stat_crc_err`=1, `stat_good`=0.
- DA=02:00:00:00:00:02, `promisc`=0 → `stat_addr_miss`=1. Broadcast DA → `addr_miss`=0. `promisc`=1 → `addr_miss`=0.
- 40-byte frame → `len_err`=1, `stat_len`=40. 1522-byte frame → `len_err`=1. 3-byte frame → no out bytes, `stat_valid`=1.
- `in_er` pulsed on byte 20 → `stat_phy_err`=1. Preamble byte 0x5D → DROP, no output until dv low, next frame accepted.
- `rst` asserted at byte 30 of a frame with dv held high → outputs 0 next cycle, no eof/stat, remainder ignored. Next frame after dv low is received correctly.
